// File: rtl/mem_port_arb_pkg.sv
// mem_port_arb_pkg: arbiter state type, requester count default and width aliases
`include "common.svh"
package mem_port_arb_pkg;
  localparam int NUM_REQ_DEF = 2;
  localparam int BW = `BANK_ADDR_WIDTH;
  localparam int CW = `COL_ADDR_WIDTH;
  localparam int DW = `TX_DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, RELEASE} arb_state_t;
endpackage

// File: rtl/arb_pick.sv
// arb_pick: one-hot winner, searching upward from i_ptr and wrapping
module arb_pick #(
  parameter int N = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_win
);
  always_comb begin
    o_win = '0;
    for (int k = N - 1; k >= 0; k--)
      if (i_req[(int'(i_ptr) + k) % N]) begin
        o_win = '0;
        o_win[(int'(i_ptr) + k) % N] = 1'b1;
      end
  end
endmodule

// File: rtl/common.svh
// common.svh: shared bank and transfer width macros
`ifndef COMMON_SVH
`define COMMON_SVH
`define BANK_ADDR_WIDTH 4
`define COL_ADDR_WIDTH 4
`define TX_DATA_WIDTH 8
`endif

// File: rtl/mem_port_arb.sv
// mem_port_arb: single-bank port arbiter issuing one latched command per grant
// ARB_RR_EN selects round-robin; otherwise fixed priority, lowest index first.
`include "common.svh"
module mem_port_arb
  import mem_port_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic [NUM_REQ-1:0]                      req_write_en,
  input  logic [NUM_REQ-1:0]                      req_read_en,
  input  logic [NUM_REQ-1:0][`BANK_ADDR_WIDTH-1:0] req_row_addr,
  input  logic [NUM_REQ-1:0][`COL_ADDR_WIDTH-1:0]  req_col_addr,
  input  logic [NUM_REQ-1:0][`TX_DATA_WIDTH-1:0]   req_partial_vec,
  output logic [NUM_REQ-1:0]                      req_ack,
  output logic [`TX_DATA_WIDTH-1:0]               req_rdata,
  output logic [NUM_REQ-1:0]                      grant,
  output logic                                    mem_write_en,
  output logic                                    mem_read_en,
  output logic [`BANK_ADDR_WIDTH-1:0]             mem_row_addr,
  output logic [`COL_ADDR_WIDTH-1:0]              mem_col_addr,
  output logic [`TX_DATA_WIDTH-1:0]               mem_partial_vec,
  input  logic                                    mem_ack,
  input  logic                                    mem_busy,
  input  logic [`TX_DATA_WIDTH-1:0]               mem_partial_vec_out
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t         r_state;
  logic [PW-1:0]      r_own;
  logic               r_wr;
  logic [NUM_REQ-1:0] w_req;
  logic [NUM_REQ-1:0] w_win;
  logic [PW-1:0]      w_ptr;
  logic [PW-1:0]      w_idx;

  assign w_req = req_write_en | req_read_en;

`ifdef ARB_RR_EN
  logic [PW-1:0] r_ptr;
  assign w_ptr = r_ptr;
  always_ff @(posedge clock) begin
    if (!reset) r_ptr <= '0;
    else if (r_state == WAIT_ACK && mem_ack) r_ptr <= PW'((int'(r_own) + 1) % NUM_REQ);
  end
`else
  assign w_ptr = '0;
`endif

  arb_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .i_req (w_req),
    .i_ptr (w_ptr),
    .o_win (w_win)
  );

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (w_win[i]) w_idx = PW'(i);
  end

  // Fields are latched at grant so owner changes mid-transaction never reach the bank
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state         <= IDLE;
      r_own           <= '0;
      r_wr            <= 1'b0;
      grant           <= '0;
      req_ack         <= '0;
      req_rdata       <= '0;
      mem_write_en    <= 1'b0;
      mem_read_en     <= 1'b0;
      mem_row_addr    <= '0;
      mem_col_addr    <= '0;
      mem_partial_vec <= '0;
    end else begin
      req_ack <= '0;
      case (r_state)
        IDLE: if (|w_req && !mem_busy) begin
          r_own           <= w_idx;
          r_wr            <= req_write_en[w_idx];
          grant           <= w_win;
          mem_row_addr    <= req_row_addr[w_idx];
          mem_col_addr    <= req_col_addr[w_idx];
          mem_partial_vec <= req_partial_vec[w_idx];
          r_state         <= ISSUE;
        end
        ISSUE: begin
          mem_write_en <= r_wr;
          mem_read_en  <= !r_wr;
          r_state      <= WAIT_ACK;
        end
        WAIT_ACK: if (mem_ack) begin
          mem_write_en <= 1'b0;
          mem_read_en  <= 1'b0;
          req_ack      <= grant;
          req_rdata    <= r_wr ? req_rdata : mem_partial_vec_out;
          r_state      <= RELEASE;
        end
        RELEASE: if (!req_write_en[r_own] && !req_read_en[r_own]) begin
          grant   <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb: directed stimulus against a transaction-level arbiter and bank model
module tb_mem_port_arb;
  import mem_port_arb_pkg::*;
  localparam int N = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset;
  logic [N-1:0]          req_write_en, req_read_en;
  logic [N-1:0][BW-1:0]  req_row_addr;
  logic [N-1:0][CW-1:0]  req_col_addr;
  logic [N-1:0][DW-1:0]  req_partial_vec;
  logic [N-1:0]          req_ack, grant;
  logic [DW-1:0]         req_rdata;
  logic                  mem_write_en, mem_read_en;
  logic [BW-1:0]         mem_row_addr;
  logic [CW-1:0]         mem_col_addr;
  logic [DW-1:0]         mem_partial_vec;
  logic                  mem_ack, mem_busy;
  logic [DW-1:0]         mem_partial_vec_out;

  mem_port_arb #(.NUM_REQ(N)) dut (
    .clock(clk), .reset(reset),
    .req_write_en(req_write_en), .req_read_en(req_read_en),
    .req_row_addr(req_row_addr), .req_col_addr(req_col_addr),
    .req_partial_vec(req_partial_vec),
    .req_ack(req_ack), .req_rdata(req_rdata), .grant(grant),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
    .mem_row_addr(mem_row_addr), .mem_col_addr(mem_col_addr),
    .mem_partial_vec(mem_partial_vec),
    .mem_ack(mem_ack), .mem_busy(mem_busy),
    .mem_partial_vec_out(mem_partial_vec_out)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // requester and bank behaviour
  logic [N-1:0] c_we, c_re, cont, rer;
  logic         bank_auto;
  int           blat, bcnt;

  // model state: owner, strobe, completion, latched command
  int            m_own = -1;
  int            m_ptr = 0;
  logic          m_str = 1'b0, m_acked = 1'b0, m_wr = 1'b0;
  logic [BW-1:0] m_row = '0;
  logic [CW-1:0] m_col = '0;
  logic [DW-1:0] m_dat = '0, m_rdata = '0;

  task automatic model_step();
    logic [N-1:0] ack_e;
    logic [N-1:0] rq;
    ack_e = '0;
    rq = req_write_en | req_read_en;
    if (!reset) begin
      m_own = -1; m_str = 1'b0; m_acked = 1'b0; m_rdata = '0; m_ptr = 0;
    end else if (m_own < 0) begin
      if (rq != 0 && !mem_busy) begin
        for (int k = 0; k < N; k++)
          if (m_own < 0 && rq[(m_ptr + k) % N]) m_own = (m_ptr + k) % N;
        m_wr = req_write_en[m_own];
        m_row = req_row_addr[m_own];
        m_col = req_col_addr[m_own];
        m_dat = req_partial_vec[m_own];
        m_acked = 1'b0;
      end
    end else if (!m_acked) begin
      if (m_str && mem_ack) begin
        m_str = 1'b0;
        m_acked = 1'b1;
        ack_e[m_own] = 1'b1;
        if (!m_wr) m_rdata = mem_partial_vec_out;
`ifdef ARB_RR_EN
        m_ptr = (m_own + 1) % N;
`endif
      end else m_str = 1'b1;
    end else if (!req_write_en[m_own] && !req_read_en[m_own]) m_own = -1;
    chk("grant", 32'(grant), (m_own < 0) ? 32'd0 : (32'd1 << m_own));
    chk("req_ack", 32'(req_ack), 32'(ack_e));
    chk("mem_write_en", 32'(mem_write_en), 32'(m_str && m_wr));
    chk("mem_read_en", 32'(mem_read_en), 32'(m_str && !m_wr));
    chk("req_rdata", 32'(req_rdata), 32'(m_rdata));
    if (!reset) begin
      chk("rst_fields", 32'({mem_row_addr, mem_col_addr, mem_partial_vec}), 32'd0);
    end else if (m_str) begin
      chk("mem_row_addr", 32'(mem_row_addr), 32'(m_row));
      chk("mem_col_addr", 32'(mem_col_addr), 32'(m_col));
      chk("mem_partial_vec", 32'(mem_partial_vec), 32'(m_dat));
    end
  endtask

  task automatic tb_drive();
    if (mem_ack) begin
      mem_ack = 1'b0; bcnt = 0;
    end else if (bank_auto && (mem_write_en || mem_read_en)) begin
      bcnt++;
      if (bcnt >= blat) mem_ack = 1'b1;
    end
    for (int i = 0; i < N; i++)
      if (req_ack[i]) begin
        req_write_en[i] = 1'b0; req_read_en[i] = 1'b0;
        rer[i] = cont[i];
      end else if (rer[i]) begin
        req_write_en[i] = c_we[i]; req_read_en[i] = c_re[i];
        rer[i] = 1'b0;
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    @(negedge clk);
    tb_drive();
  endtask

  task automatic set_req(input int i, input logic we, input logic re, input int row, input int col, input int d);
    c_we[i] = we; c_re[i] = re;
    req_write_en[i] = we; req_read_en[i] = re;
    req_row_addr[i] = BW'(row); req_col_addr[i] = CW'(col); req_partial_vec[i] = DW'(d);
  endtask

  task automatic wait_done(input string name);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 60 && !ok; c++) begin
      tick();
      ok = ((req_write_en | req_read_en) == 0) && (grant == 0);
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  logic [N-1:0] order [4];
  int           nack;
  logic         got, seen_wr;

  initial begin
    reset = 1'b0;
    req_write_en = '0; req_read_en = '0;
    req_row_addr = '0; req_col_addr = '0; req_partial_vec = '0;
    mem_ack = 1'b0; mem_busy = 1'b0; mem_partial_vec_out = '0;
    c_we = '0; c_re = '0; cont = '0; rer = '0;
    bank_auto = 1'b1; blat = 2; bcnt = 0;
    tick(); tick();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_strobes", 32'({mem_write_en, mem_read_en}), 32'd0);
    chk("rst_rdata", 32'(req_rdata), 32'd0);
    reset = 1'b1;
    tick();
    chk("idle_grant", 32'(grant), 32'd0);

    // loader writes 0xA5 to row 3 col 0, bank acks 2 cycles after the strobe
    set_req(0, 1'b1, 1'b0, 3, 0, 'hA5);
    tick(); chk("wr_grant", 32'(grant), 32'd1); chk("wr_nostrobe", 32'(mem_write_en), 32'd0);
    tick(); chk("wr_strobe1", 32'(mem_write_en), 32'd1); chk("wr_data", 32'(mem_partial_vec), 32'hA5);
    chk("wr_row", 32'(mem_row_addr), 32'd3);
    tick(); chk("wr_strobe2", 32'(mem_write_en), 32'd1); chk("wr_noack", 32'(req_ack), 32'd0);
    tick(); chk("wr_ack", 32'(req_ack), 32'd1); chk("wr_drop", 32'(mem_write_en), 32'd0);
    chk("wr_grant_held", 32'(grant), 32'd1);
    tick(); chk("wr_release", 32'(grant), 32'd0); chk("wr_ack_once", 32'(req_ack), 32'd0);

    // machine reads row 5; owner flips to write and row 7 mid-transaction
    blat = 4; mem_partial_vec_out = 'h3C;
    set_req(1, 1'b0, 1'b1, 5, 2, 0);
    got = 1'b0; seen_wr = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      tick();
      seen_wr |= mem_write_en;
      if (c == 2) begin req_row_addr[1] = BW'(7); req_write_en[1] = 1'b1; end
      if (req_ack[1]) begin got = 1'b1; chk("rd_rdata", 32'(req_rdata), 32'h3C); end
    end
    chk("rd_acked", 32'(got), 32'd1);
    chk("rd_no_write", 32'(seen_wr), 32'd0);
    wait_done("rd_done");

`ifndef ARB_RR_EN
    // simultaneous requests, fixed priority
    blat = 1; nack = 0;
    set_req(0, 1'b1, 1'b0, 1, 1, 'h11);
    set_req(1, 1'b1, 1'b0, 2, 2, 'h22);
    for (int c = 0; c < 40 && nack < 2; c++) begin
      tick();
      if (req_ack != 0) begin order[nack] = req_ack; nack++; end
    end
    chk("fp_acks", 32'(nack), 32'd2);
    chk("fp_first", 32'(order[0]), 32'd1);
    chk("fp_second", 32'(order[1]), 32'd2);
    wait_done("fp_done");
`endif

    // both requesters continuously requesting
    blat = 1; nack = 0; cont = 2'b11; mem_partial_vec_out = 'h5A;
    set_req(0, 1'b1, 1'b0, 4, 1, 'h44);
    set_req(1, 1'b0, 1'b1, 6, 3, 0);
    for (int c = 0; c < 60 && nack < 4; c++) begin
      tick();
      if (req_ack != 0) begin order[nack] = grant; nack++; end
    end
    cont = '0; rer = '0;
    chk("cont_acks", 32'(nack), 32'd4);
`ifdef ARB_RR_EN
    chk("rr_g0", 32'(order[0]), 32'd1); chk("rr_g1", 32'(order[1]), 32'd2);
    chk("rr_g2", 32'(order[2]), 32'd1); chk("rr_g3", 32'(order[3]), 32'd2);
`else
    chk("fp_g0", 32'(order[0]), 32'd1); chk("fp_g1", 32'(order[1]), 32'd1);
    chk("fp_g2", 32'(order[2]), 32'd1); chk("fp_g3", 32'(order[3]), 32'd1);
`endif
    wait_done("cont_done");

    // bank busy holds off a pending write+read (served as write)
    blat = 2; mem_busy = 1'b1;
    set_req(0, 1'b1, 1'b1, 2, 3, 'h77);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("busy_grant", 32'(grant), 32'd0);
      chk("busy_strobe", 32'({mem_write_en, mem_read_en}), 32'd0);
    end
    mem_busy = 1'b0;
    tick(); chk("busy_grant_after", 32'(grant), 32'd1); chk("busy_nostrobe", 32'(mem_write_en), 32'd0);
    tick(); chk("busy_strobe_wr", 32'(mem_write_en), 32'd1); chk("busy_strobe_rd", 32'(mem_read_en), 32'd0);
    wait_done("busy_done");

    // reset during WAIT_ACK, bank acks afterwards
    bank_auto = 1'b0; bcnt = 0;
    set_req(1, 1'b1, 1'b0, 8, 1, 'h99);
    tick(); tick(); tick();
    chk("abort_strobe_before", 32'(mem_write_en), 32'd1);
    reset = 1'b0; req_write_en = '0; req_read_en = '0;
    tick();
    chk("abort_strobe", 32'(mem_write_en), 32'd0);
    chk("abort_grant", 32'(grant), 32'd0);
    chk("abort_noack", 32'(req_ack), 32'd0);
    reset = 1'b1; mem_ack = 1'b1;
    tick(); chk("late_ack", 32'(req_ack), 32'd0);
    tick(); chk("late_ack2", 32'(req_ack), 32'd0); chk("late_grant", 32'(grant), 32'd0);
    bank_auto = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
